rvfpm_issue_queue: RTL and testbench
====================================

RVFPM_ISSUE_QUEUE -- requirements
Module: rvfpm_issue_queue

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, width of offload instruction id.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, number of entries; power of two, >=2.
REQ-003 SHALL have parameter XLEN, default 32, integer operand width.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports: ck in 1 clock; rst in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: issue_valid in 1 offload request valid; issue_ready out 1 queue can accept; issue_instr in 32 instruction word; issue_id in X_ID_WIDTH instruction id; issue_rs0/issue_rs1/issue_rs2 in XLEN integer operands.
REQ-006 SHALL have ports: commit_valid in 1 commit strobe; commit_kill in 1 kill flag; commit_id in X_ID_WIDTH committed id.
REQ-007 SHALL have ports: pipe_valid out 1 head offered to FPU pipeline; pipe_ready in 1 pipeline accepts; pipe_instr out 32; pipe_id out X_ID_WIDTH; pipe_rs0/pipe_rs1/pipe_rs2 out XLEN.
REQ-008 SHALL have ports: queue_ids out QUEUE_DEPTH*X_ID_WIDTH slot ids ordered from head; queue_vld out QUEUE_DEPTH slot occupied flags; count out $clog2(QUEUE_DEPTH)+1 occupancy.

Function
REQ-009 SHALL be a FIFO with head/tail pointers wrapping modulo QUEUE_DEPTH.
REQ-010 SHALL drive issue_ready = (count < QUEUE_DEPTH), independent of pipe_ready and issue_valid.
REQ-011 SHALL push on issue_valid && issue_ready at the rising ck edge, storing instr, id, rs0-2, killed=0.
REQ-012 SHALL assert pipe_valid when count>0 and head entry not killed; pipe_* outputs driven from head entry; values held stable while pipe_valid && !pipe_ready.
REQ-013 SHALL pop head on pipe_valid && pipe_ready; minimum push-to-pipe_valid latency 1 cycle (see REQ-021).
REQ-014 SHALL, on commit_valid && commit_kill, set killed on every stored entry whose id equals commit_id; an entry pushed in the same cycle is not affected.
REQ-015 SHALL discard a killed head entry in one cycle with pipe_valid low; at most one discard or pop per cycle.
REQ-016 SHALL, on simultaneous push and pop/discard, leave count unchanged; full queue with pop frees one slot next cycle only (no same-cycle push when full).
REQ-017 SHALL ignore commit_valid with commit_kill=0 (no state change).
REQ-018 SHALL drive queue_vld[i]=1 and queue_ids slot i for the i-th entry from head, i<count; unused slots 0.

Reset
REQ-019 SHALL, while rst=0, asynchronously clear pointers, count=0, all valid/killed flags, pipe_valid=0, issue_ready=0, queue_vld=0, queue_ids=0, pipe_* data=0.
REQ-020 SHALL assert issue_ready=1 in the first cycle after rst deasserts; reset mid-operation drops all entries without dispatch.

Configuration
REQ-021 SHALL support macro RVFPM_QUEUE_BYPASS_EN: when defined and queue empty, issue_valid with pipe_ready passes issue_* to pipe_* combinationally in the same cycle without storing (pipe_valid=issue_valid); when undefined, every instruction is stored and reaches pipe_valid no earlier than the next cycle.

Verification
REQ-022 SHALL cover: reset release -> count=0, issue_ready=1, pipe_valid=0.
REQ-023 SHALL cover: push ids 1,2,3,4 with pipe_ready=0 -> count=4, issue_ready=0, queue_ids head-first 1,2,3,4; then pipe_ready=1 -> pipe_id 1,2,3,4 on consecutive cycles.
REQ-024 SHALL cover: ids 5,6,7 queued, commit_kill id 6 -> pipe outputs 5 then 7, id 6 never on pipe_valid, count reaches 0.
REQ-025 SHALL cover: full queue, pipe_ready=1 and issue_valid=1 same cycle -> no push that cycle, push accepted next cycle, count 4->3->3.
REQ-026 SHALL cover: rst asserted with 3 entries -> count=0 and pipe_valid=0 immediately, no entry dispatched after release.
REQ-027 SHALL cover: empty queue, pipe_ready=1, push id 9 -> with RVFPM_QUEUE_BYPASS_EN pipe_id=9 same cycle, count stays 0; without, pipe_id=9 next cycle.

Source files
------------

// File: rtl/rvfpm_issue_queue_if.sv
// Offload issue / commit / FPU-pipe handshake bundle for rvfpm_issue_queue.
// slave = the queue, master = the core + FPU pipeline side.
interface rvfpm_issue_queue_if #(
   parameter int X_ID_WIDTH = 4,
   parameter int XLEN       = 32
);
   logic                  issue_valid;
   logic                  issue_ready;
   logic [31:0]           issue_instr;
   logic [X_ID_WIDTH-1:0] issue_id;
   logic [XLEN-1:0]       issue_rs0, issue_rs1, issue_rs2;

   logic                  commit_valid;
   logic                  commit_kill;
   logic [X_ID_WIDTH-1:0] commit_id;

   logic                  pipe_valid;
   logic                  pipe_ready;
   logic [31:0]           pipe_instr;
   logic [X_ID_WIDTH-1:0] pipe_id;
   logic [XLEN-1:0]       pipe_rs0, pipe_rs1, pipe_rs2;

   modport master (
      output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs2,
      output commit_valid, commit_kill, commit_id, pipe_ready,
      input  issue_ready, pipe_valid, pipe_instr, pipe_id, pipe_rs0, pipe_rs1, pipe_rs2
   );
   modport slave (
      input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs2,
      input  commit_valid, commit_kill, commit_id, pipe_ready,
      output issue_ready, pipe_valid, pipe_instr, pipe_id, pipe_rs0, pipe_rs1, pipe_rs2
   );
endinterface

// File: rtl/rvfpm_issue_queue.sv
// In-order offload issue queue for the FPU pipeline with commit-kill of queued ids.
// Define RVFPM_QUEUE_BYPASS_EN to pass an instruction straight through an empty queue.
module rvfpm_issue_queue #(
   parameter int X_ID_WIDTH  = 4,
   parameter int QUEUE_DEPTH = 4,
   parameter int XLEN        = 32
) (
   input  logic                              ck,
   input  logic                              rst,
   rvfpm_issue_queue_if.slave                io,
   output logic [QUEUE_DEPTH*X_ID_WIDTH-1:0] queue_ids,
   output logic [QUEUE_DEPTH-1:0]            queue_vld,
   output logic [$clog2(QUEUE_DEPTH):0]      count
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]           instr;
      logic [X_ID_WIDTH-1:0] id;
      logic [XLEN-1:0]       rs0;
      logic [XLEN-1:0]       rs1;
      logic [XLEN-1:0]       rs2;
   } entry_t;

   entry_t [QUEUE_DEPTH-1:0] ent_q, ent_d;
   logic   [QUEUE_DEPTH-1:0] kill_q, kill_d;
   logic   [QUEUE_DEPTH-1:0] occ;
   logic   [PW-1:0]          head_q, head_d, tail_q, tail_d;
   logic   [CW-1:0]          cnt_q, cnt_d;
   logic                     push, deq, head_pv, byp;
   entry_t                   in_e, head_e, out_e;

   assign in_e    = '{instr: io.issue_instr, id: io.issue_id,
                      rs0: io.issue_rs0, rs1: io.issue_rs1, rs2: io.issue_rs2};
   assign head_e  = ent_q[head_q];
   assign head_pv = (cnt_q != '0) && !kill_q[head_q];
   // A killed head is dropped without waiting on pipe_ready.
   assign deq     = (cnt_q != '0) && (kill_q[head_q] || io.pipe_ready);

`ifdef RVFPM_QUEUE_BYPASS_EN
   assign byp = rst && (cnt_q == '0) && io.pipe_ready;
`else
   assign byp = 1'b0;
`endif

   assign io.issue_ready = rst && (cnt_q < CW'(QUEUE_DEPTH));
   assign push           = io.issue_valid && io.issue_ready && !byp;

   assign out_e         = byp ? in_e : head_e;
   assign io.pipe_valid = byp ? io.issue_valid : head_pv;
   assign io.pipe_instr = out_e.instr;
   assign io.pipe_id    = out_e.id;
   assign io.pipe_rs0   = out_e.rs0;
   assign io.pipe_rs1   = out_e.rs1;
   assign io.pipe_rs2   = out_e.rs2;
   assign count         = cnt_q;

   for (genvar j = 0; j < QUEUE_DEPTH; j++) begin : g_slot
      logic [PW-1:0] off, idx;
      assign off     = PW'(j) - head_q;
      assign occ[j]  = CW'(off) < cnt_q;
      assign idx     = head_q + PW'(j);
      assign queue_vld[j] = CW'(j) < cnt_q;
      assign queue_ids[j*X_ID_WIDTH +: X_ID_WIDTH] = queue_vld[j] ? ent_q[idx].id : '0;
   end

   always_comb begin
      ent_d  = ent_q;
      kill_d = kill_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q + CW'(push) - CW'(deq);
      if (io.commit_valid && io.commit_kill) begin
         for (int j = 0; j < QUEUE_DEPTH; j++)
            if (occ[j] && (ent_q[j].id == io.commit_id)) kill_d[j] = 1'b1;
      end
      if (deq) head_d = head_q + PW'(1);
      // The slot being written is free, so a same-cycle kill never reaches it.
      if (push) begin
         ent_d[tail_q]  = in_e;
         kill_d[tail_q] = 1'b0;
         tail_d         = tail_q + PW'(1);
      end
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         ent_q  <= '0;
         kill_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         ent_q  <= ent_d;
         kill_q <= kill_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Self-checking bench for rvfpm_issue_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_rvfpm_issue_queue;
   localparam int W  = 4;
   localparam int D  = 4;
   localparam int XL = 32;

   logic ck  = 1'b0;
   logic rst = 1'b0;
   always #5 ck = ~ck;

   rvfpm_issue_queue_if #(.X_ID_WIDTH(W), .XLEN(XL)) pif();
   logic [D*W-1:0]      queue_ids;
   logic [D-1:0]        queue_vld;
   logic [$clog2(D):0]  count;

   rvfpm_issue_queue #(.X_ID_WIDTH(W), .QUEUE_DEPTH(D), .XLEN(XL)) dut (
      .ck(ck), .rst(rst), .io(pif.slave),
      .queue_ids(queue_ids), .queue_vld(queue_vld), .count(count)
   );

   typedef struct {
      logic [W-1:0]  id;
      logic [31:0]   instr;
      logic [XL-1:0] rs0, rs1, rs2;
      bit            killed;
   } ent_t;

   ent_t         mq[$];
   logic [W-1:0] dut_log[$];
   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: in-order list; killed entries linger until they reach the head.
   always @(posedge ck or negedge rst) begin
      if (!rst) mq.delete();
      else begin
         int n;
         bit byp;
         ent_t e;
         n   = mq.size();
         byp = 1'b0;
`ifdef RVFPM_QUEUE_BYPASS_EN
         byp = (n == 0) && pif.pipe_ready && pif.issue_valid;
`endif
         if (n > 0 && (mq[0].killed || pif.pipe_ready)) void'(mq.pop_front());
         if (pif.commit_valid && pif.commit_kill)
            foreach (mq[i]) if (mq[i].id == pif.commit_id) mq[i].killed = 1'b1;
         if (pif.issue_valid && n < D && !byp) begin
            e.id = pif.issue_id; e.instr = pif.issue_instr;
            e.rs0 = pif.issue_rs0; e.rs1 = pif.issue_rs1; e.rs2 = pif.issue_rs2;
            e.killed = 1'b0;
            mq.push_back(e);
         end
      end
   end

   always @(posedge ck)
      if (rst && pif.pipe_valid && pif.pipe_ready) dut_log.push_back(pif.pipe_id);

   function automatic bit exp_pv();
      if (mq.size() == 0) begin
`ifdef RVFPM_QUEUE_BYPASS_EN
         return pif.pipe_ready && pif.issue_valid;
`else
         return 1'b0;
`endif
      end
      return !mq[0].killed;
   endfunction

   function automatic ent_t exp_head();
      ent_t e;
      if (mq.size() > 0) return mq[0];
      e.id = pif.issue_id; e.instr = pif.issue_instr;
      e.rs0 = pif.issue_rs0; e.rs1 = pif.issue_rs1; e.rs2 = pif.issue_rs2;
      e.killed = 1'b0;
      return e;
   endfunction

   function automatic logic [D*W-1:0] exp_qids();
      logic [D*W-1:0] r;
      r = '0;
      for (int i = 0; i < mq.size(); i++) r[i*W +: W] = mq[i].id;
      return r;
   endfunction

   function automatic logic [D-1:0] exp_qvld();
      logic [D-1:0] r;
      r = '0;
      for (int i = 0; i < mq.size(); i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic drive(input bit v, input logic [W-1:0] id, input bit pr,
                        input bit cv = 1'b0, input bit kill = 1'b0,
                        input logic [W-1:0] cid = '0);
      @(negedge ck);
      pif.issue_valid  = v;
      pif.issue_id     = id;
      pif.issue_instr  = $urandom;
      pif.issue_rs0    = $urandom;
      pif.issue_rs1    = $urandom;
      pif.issue_rs2    = $urandom;
      pif.pipe_ready   = pr;
      pif.commit_valid = cv;
      pif.commit_kill  = kill;
      pif.commit_id    = cid;
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge ck);
      #1;
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
      n_tests++; if (pif.issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_issue_ready got %b exp 0", pif.issue_ready); end
      n_tests++; if (pif.pipe_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pipe_valid got %b exp 0", pif.pipe_valid); end
      n_tests++; if (queue_vld !== '0 || queue_ids !== '0 || pif.pipe_id !== '0 || pif.pipe_instr !== '0)
         begin n_fail++; $display("FAIL rst_outputs vld %h ids %h pid %h pinstr %h exp all 0", queue_vld, queue_ids, pif.pipe_id, pif.pipe_instr); end
      @(negedge ck);
      rst = 1'b1;
      #1;
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rel_count got %0d exp 0", count); end
      n_tests++; if (pif.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rel_issue_ready got %b exp 1", pif.issue_ready); end
      n_tests++; if (pif.pipe_valid !== 1'b0) begin n_fail++; $display("FAIL rel_pipe_valid got %b exp 0", pif.pipe_valid); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 4; i++) drive(1'b1, W'(i), 1'b0);
      drive(1'b0, '0, 1'b0);
      n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
      n_tests++; if (pif.issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_issue_ready got %b exp 0", pif.issue_ready); end
      n_tests++; if (queue_ids !== 16'h4321 || queue_vld !== 4'hF)
         begin n_fail++; $display("FAIL fill_ids got %h/%h exp 4321/f", queue_ids, queue_vld); end
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, '0, 1'b1);
         n_tests++; if (pif.pipe_valid !== 1'b1 || pif.pipe_id !== W'(i))
            begin n_fail++; $display("FAIL drain_id got v%b id %0d exp v1 id %0d", pif.pipe_valid, pif.pipe_id, i); end
      end
      drive(1'b0, '0, 1'b0);
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count); end
   endtask

   task automatic test_kill();
      dut_log.delete();
      drive(1'b1, 4'd5, 1'b0);
      drive(1'b1, 4'd6, 1'b0);
      drive(1'b1, 4'd7, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd6);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, '0, 1'b1);
         n_tests++; if (pif.pipe_valid !== exp_pv() || (exp_pv() && pif.pipe_id !== exp_head().id))
            begin n_fail++; $display("FAIL kill_pipe cyc %0d got v%b id %0d exp v%b id %0d", i, pif.pipe_valid, pif.pipe_id, exp_pv(), exp_head().id); end
      end
      n_tests++; if (dut_log.size() != 2 || dut_log[0] !== 4'd5 || dut_log[1] !== 4'd7)
         begin n_fail++; $display("FAIL kill_seq got %p exp '{5,7}", dut_log); end
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL kill_count got %0d exp 0", count); end
   endtask

   task automatic test_full_push();
      for (int i = 10; i <= 13; i++) drive(1'b1, W'(i), 1'b0);
      drive(1'b1, 4'd14, 1'b1);
      n_tests++; if (pif.issue_ready !== 1'b0 || count !== 3'd4)
         begin n_fail++; $display("FAIL full_c0 got rdy %b cnt %0d exp rdy 0 cnt 4", pif.issue_ready, count); end
      drive(1'b1, 4'd14, 1'b1);
      n_tests++; if (pif.issue_ready !== 1'b1 || count !== 3'd3)
         begin n_fail++; $display("FAIL full_c1 got rdy %b cnt %0d exp rdy 1 cnt 3", pif.issue_ready, count); end
      drive(1'b0, '0, 1'b0);
      n_tests++; if (count !== 3'd3 || queue_ids !== 16'h0EDC)
         begin n_fail++; $display("FAIL full_c2 got cnt %0d ids %h exp cnt 3 ids 0edc", count, queue_ids); end
      repeat (3) drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d exp 0", count); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 4'd1, 1'b0);
      drive(1'b1, 4'd2, 1'b0);
      drive(1'b1, 4'd3, 1'b0);
      drive(1'b0, '0, 1'b0);
      n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL midrst_pre got %0d exp 3", count); end
      dut_log.delete();
      @(negedge ck);
      rst = 1'b0;
      #1;
      n_tests++; if (count !== 3'd0 || pif.pipe_valid !== 1'b0 || pif.issue_ready !== 1'b0 || queue_vld !== '0)
         begin n_fail++; $display("FAIL midrst_now got cnt %0d pv %b rdy %b vld %h exp 0 0 0 0", count, pif.pipe_valid, pif.issue_ready, queue_vld); end
      @(negedge ck);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1);
         n_tests++; if (pif.pipe_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_pv cyc %0d got %b exp 0", i, pif.pipe_valid); end
      end
      n_tests++; if (dut_log.size() != 0) begin n_fail++; $display("FAIL midrst_disp got %0d exp 0", dut_log.size()); end
   endtask

   task automatic test_bypass();
      drive(1'b1, 4'd9, 1'b1);
`ifdef RVFPM_QUEUE_BYPASS_EN
      n_tests++; if (pif.pipe_valid !== 1'b1 || pif.pipe_id !== 4'd9)
         begin n_fail++; $display("FAIL byp_same got v%b id %0d exp v1 id 9", pif.pipe_valid, pif.pipe_id); end
      drive(1'b0, '0, 1'b0);
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count got %0d exp 0", count); end
`else
      n_tests++; if (pif.pipe_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_same got %b exp 0", pif.pipe_valid); end
      drive(1'b0, '0, 1'b1);
      n_tests++; if (pif.pipe_valid !== 1'b1 || pif.pipe_id !== 4'd9)
         begin n_fail++; $display("FAIL nobyp_next got v%b id %0d exp v1 id 9", pif.pipe_valid, pif.pipe_id); end
      drive(1'b0, '0, 1'b0);
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL nobyp_count got %0d exp 0", count); end
`endif
   endtask

   task automatic test_random();
      ent_t h;
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 9) < 6, W'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)));
         h = exp_head();
         n_tests++; if (pif.issue_ready !== (mq.size() < D))
            begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, pif.issue_ready, mq.size() < D); end
         n_tests++; if (pif.pipe_valid !== exp_pv())
            begin n_fail++; $display("FAIL rnd_pv cyc %0d got %b exp %b", c, pif.pipe_valid, exp_pv()); end
         if (exp_pv()) begin
            n_tests++;
            if (pif.pipe_id !== h.id || pif.pipe_instr !== h.instr || pif.pipe_rs0 !== h.rs0 ||
                pif.pipe_rs1 !== h.rs1 || pif.pipe_rs2 !== h.rs2)
               begin n_fail++; $display("FAIL rnd_data cyc %0d got id %0d instr %h exp id %0d instr %h", c, pif.pipe_id, pif.pipe_instr, h.id, h.instr); end
         end
         n_tests++; if (count !== 3'(mq.size()) || queue_vld !== exp_qvld() || queue_ids !== exp_qids())
            begin n_fail++; $display("FAIL rnd_state cyc %0d got cnt %0d vld %h ids %h exp cnt %0d vld %h ids %h", c, count, queue_vld, queue_ids, mq.size(), exp_qvld(), exp_qids()); end
      end
      repeat (8) drive(1'b0, '0, 1'b1);
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rnd_drain got %0d exp 0", count); end
   endtask

   initial begin
      pif.issue_valid = 1'b0; pif.issue_id = '0; pif.issue_instr = '0;
      pif.issue_rs0 = '0; pif.issue_rs1 = '0; pif.issue_rs2 = '0;
      pif.commit_valid = 1'b0; pif.commit_kill = 1'b0; pif.commit_id = '0;
      pif.pipe_ready = 1'b0;
      test_reset();
      test_fill_drain();
      test_kill();
      test_full_push();
      test_reset_mid();
      test_bypass();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
